// File: rtl/parity_pkg.sv
// Shared types and constants for the streaming parity generator/checker.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

endpackage

// File: rtl/word_parity.sv
// Combinational XOR reduce of a single data beat.
module word_parity #(
    parameter int WORDSIZE = 8
) (
    input  logic [WORDSIZE-1:0] data,
    output logic                parity
);

    assign parity = ^data;

endmodule

// File: rtl/parity_stream.sv
// Streaming parity generator/checker: accumulates parity over a packet of beats,
// checks it against the parity bit carried on the last beat and counts errors.
module parity_stream
    import parity_pkg::*;
#(
    parameter int WORDSIZE = 8,
    parameter int LEN_W    = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                odd_mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDSIZE-1:0] in_data,
    input  logic                in_last,
    input  logic                in_parity,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_parity,
    output logic                out_error,
    output logic [LEN_W-1:0]    out_len,
    output logic [CNT_W-1:0]    err_count
);

    logic beat_par;

    word_parity #(.WORDSIZE(WORDSIZE)) u_word_parity (
        .data   (in_data),
        .parity (beat_par)
    );

    state_t           state_reg, state_next;
    logic             acc_reg, acc_next;
    logic             mode_reg, mode_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic             out_parity_reg, out_parity_next;
    logic             out_error_reg, out_error_next;
    logic [LEN_W-1:0] out_len_reg, out_len_next;
    logic [CNT_W-1:0] err_count_reg, err_count_next;
    logic             accept;
    logic             finish;
    logic             final_par;

    assign in_ready   = (state_reg != RESULT);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_reg == RESULT);
    assign out_parity = out_parity_reg;
    assign out_error  = out_error_reg;
    assign out_len    = out_len_reg;
    assign err_count  = err_count_reg;

    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        mode_next       = mode_reg;
        len_next        = len_reg;
        out_parity_next = out_parity_reg;
        out_error_next  = out_error_reg;
        out_len_next    = out_len_reg;
        err_count_next  = err_count_reg;
        finish          = 1'b0;
        final_par       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    mode_next  = odd_mode ? MODE_ODD : MODE_EVEN;
                    acc_next   = beat_par;
                    len_next   = LEN_W'(1);
                    state_next = ACCUM;
                    finish     = in_last;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_next = acc_reg ^ beat_par;
                    len_next = (&len_reg) ? len_reg : len_reg + LEN_W'(1);
                    finish   = in_last;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // The result is built from the *next* accumulator/length so the last beat counts.
        if (finish) begin
            final_par       = acc_next ^ mode_next;
            out_parity_next = final_par;
            out_error_next  = (final_par != in_parity);
            out_len_next    = len_next;
            state_next      = RESULT;
            if ((final_par != in_parity) && !(&err_count_reg)) begin
                err_count_next = err_count_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            acc_reg        <= 1'b0;
            mode_reg       <= MODE_EVEN;
            len_reg        <= '0;
            out_parity_reg <= 1'b0;
            out_error_reg  <= 1'b0;
            out_len_reg    <= '0;
            err_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            mode_reg       <= mode_next;
            len_reg        <= len_next;
            out_parity_reg <= out_parity_next;
            out_error_reg  <= out_error_next;
            out_len_reg    <= out_len_next;
            err_count_reg  <= err_count_next;
        end
    end

endmodule

// File: tb/tb_parity_stream.sv
// Randomized self-checking bench for parity_stream: a default-width instance and a
// narrow-counter instance share one stimulus stream and one packet-level reference model.
module tb_parity_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       odd_mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_parity = 1'b0;
    logic       out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, out_parity_a, out_error_a;
    logic [7:0]  out_len_a;
    logic [15:0] err_count_a;
    logic        in_ready_b, out_valid_b, out_parity_b, out_error_b;
    logic [1:0]  out_len_b;
    logic [1:0]  err_count_b;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] pkt [0:511];
    bit         exp_par;
    bit         exp_err;
    int         exp_len_a, exp_len_b;
    int         exp_cnt_a, exp_cnt_b;
    int         pkt_no = 0;

    always #5 clk = ~clk;

    parity_stream #(.WORDSIZE(8), .LEN_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .odd_mode(odd_mode), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .in_parity(in_parity), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_parity(out_parity_a), .out_error(out_error_a), .out_len(out_len_a),
        .err_count(err_count_a)
    );

    parity_stream #(.WORDSIZE(8), .LEN_W(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .odd_mode(odd_mode), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .in_parity(in_parity), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_parity(out_parity_b), .out_error(out_error_b), .out_len(out_len_b),
        .err_count(err_count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string t, input bit valid, input bit rdy);
        check({t, "_rdy_a"}, 32'(in_ready_a), 32'(rdy));
        check({t, "_rdy_b"}, 32'(in_ready_b), 32'(rdy));
        check({t, "_vld_a"}, 32'(out_valid_a), 32'(valid));
        check({t, "_vld_b"}, 32'(out_valid_b), 32'(valid));
        check({t, "_par_a"}, 32'(out_parity_a), 32'(exp_par));
        check({t, "_par_b"}, 32'(out_parity_b), 32'(exp_par));
        check({t, "_err_a"}, 32'(out_error_a), 32'(exp_err));
        check({t, "_err_b"}, 32'(out_error_b), 32'(exp_err));
        check({t, "_len_a"}, 32'(out_len_a), 32'(exp_len_a));
        check({t, "_len_b"}, 32'(out_len_b), 32'(exp_len_b));
        check({t, "_cnt_a"}, 32'(err_count_a), 32'(exp_cnt_a));
        check({t, "_cnt_b"}, 32'(err_count_b), 32'(exp_cnt_b));
    endtask

    // Reset takes effect immediately, so outputs are checked while rst is still high.
    task automatic do_reset(input string t);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_par = 0; exp_err = 0; exp_len_a = 0; exp_len_b = 0;
        exp_cnt_a = 0; exp_cnt_b = 0;
        check_outputs(t, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
    endtask

    // Drive pkt[0..n-1] as one packet; gap idle cycles before each later beat,
    // result held for hold cycles before being taken.
    task automatic run_packet(input int n, input bit mode, input bit want_err,
                              input int gap, input int hold);
        int ones = 0;
        bit good_par;
        for (int i = 0; i < n; i++) ones += $countones(pkt[i]);
        good_par = bit'(ones % 2) ^ mode;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid  = 1'b0;
                    odd_mode  = 1'($urandom);
                    in_data   = 8'($urandom);
                    in_last   = 1'($urandom);
                    in_parity = 1'($urandom);
                    @(negedge clk);
                end
            end
            in_valid  = 1'b1;
            in_data   = pkt[i];
            in_last   = (i == n - 1);
            in_parity = (i == n - 1) ? (good_par ^ want_err) : 1'($urandom);
            odd_mode  = (i == 0) ? mode : 1'($urandom);
            check("beat_rdy", 32'(in_ready_a & in_ready_b), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        exp_par   = good_par;
        exp_err   = want_err;
        exp_len_a = (n > 255) ? 255 : n;
        exp_len_b = (n > 3) ? 3 : n;
        if (want_err) begin
            exp_cnt_a = (exp_cnt_a >= 65535) ? 65535 : exp_cnt_a + 1;
            exp_cnt_b = (exp_cnt_b >= 3) ? 3 : exp_cnt_b + 1;
        end
        check_outputs("res", 1'b1, 1'b0);
        $display("pkt %0d len=%0d mode=%0d par=%0d err=%0d cnt=%0d", pkt_no, n, mode,
                 exp_par, exp_err, exp_cnt_a);
        pkt_no++;

        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            in_last   = 1'($urandom);
            odd_mode  = 1'($urandom);
            @(negedge clk);
            check_outputs("hold", 1'b1, 1'b0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_outputs("rel", 1'b0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("rst0");
        repeat (3) @(negedge clk);
        check_outputs("idle", 1'b0, 1'b1);

        // even, 0x01 0x03 0x07: six ones -> parity 0, matches in_parity 0
        pkt[0] = 8'h01; pkt[1] = 8'h03; pkt[2] = 8'h07;
        run_packet(3, 1'b0, 1'b0, 0, 0);

        // odd single beat 0xA5: parity 1, in_parity 0 -> error, held 5 cycles
        pkt[0] = 8'hA5;
        run_packet(1, 1'b1, 1'b1, 0, 5);

        // gaps of 3 cycles with odd_mode toggling between beats
        fill_random(4);
        run_packet(4, 1'b0, 1'b0, 3, 1);
        fill_random(3);
        run_packet(3, 1'b1, 1'b0, 3, 0);

        // length saturation on both instances
        fill_random(5);
        run_packet(5, 1'b0, 1'b0, 0, 0);
        fill_random(300);
        run_packet(300, 1'b1, 1'b0, 0, 0);

        // error counter saturation on the narrow instance
        for (int k = 0; k < 5; k++) begin
            fill_random(2);
            run_packet(2, 1'($urandom), 1'b1, 0, 0);
        end

        // abort after two beats of a packet
        fill_random(2);
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'b1;
            in_data   = pkt[i];
            in_last   = 1'b0;
            odd_mode  = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        do_reset("abort");
        pkt[0] = 8'h00; pkt[1] = 8'h00;
        run_packet(2, 1'b0, 1'b0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            int n;
            n = $urandom_range(1, 8);
            fill_random(n);
            run_packet(n, 1'($urandom), 1'($urandom), $urandom_range(0, 2),
                       $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
